// File: rtl/game_pkg.sv
// game_pkg: shared command/state types and board constants for the game board controller.
package game_pkg;
  localparam int BOARD_MAX = 16;
  localparam int CELL_W = 5;
  localparam int DEFAULT_SIZE = 3;
  typedef enum logic [2:0] {
    CMD_NOP, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_WRITE, CMD_NEW_GAME, CMD_END_GAME
  } game_cmd_t;
  typedef enum logic [1:0] {IDLE, CLEAR, PLAY} game_state_t;
endpackage

// File: rtl/game_board_ctl_if.sv
// game_board_ctl_if: player command valid/ready bus into the board controller.
interface game_board_ctl_if;
  import game_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  game_cmd_t cmd_code;
  logic [CELL_W-1:0] cmd_digit;
  logic [2:0] size_sel;
  modport master(output cmd_valid, cmd_code, cmd_digit, size_sel, input cmd_ready);
  modport slave(input cmd_valid, cmd_code, cmd_digit, size_sel, output cmd_ready);
endinterface

// File: rtl/game_board_cursor.sv
// game_board_cursor: row/col cursor that wraps within 0..N-1.
module game_board_cursor (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic [4:0] i_n,
  output logic [3:0] o_row,
  output logic [3:0] o_col
);
  logic [3:0] r_row, r_col, w_last;
  assign w_last = 4'(i_n - 5'd1);
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (i_up) r_row <= r_row == '0 ? w_last : r_row - 4'd1;
      else if (i_down) r_row <= r_row == w_last ? '0 : r_row + 4'd1;
      if (i_left) r_col <= r_col == '0 ? w_last : r_col - 4'd1;
      else if (i_right) r_col <= r_col == w_last ? '0 : r_col + 4'd1;
    end
  end
  assign o_row = r_row;
  assign o_col = r_col;
endmodule

// File: rtl/game_board_ctl.sv
// game_board_ctl: board state, cursor and game-size owner for the numbers draw stage.
module game_board_ctl
  import game_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  game_board_ctl_if.slave                                  bus,
  output logic [BOARD_MAX-1:0][BOARD_MAX-1:0][CELL_W-1:0] o_board,
  output logic [2:0]                                       o_board_size,
  output logic                                             o_is_game_on,
  output logic [3:0]                                       o_cursor_row,
  output logic [3:0]                                       o_cursor_col,
  output logic [8:0]                                       o_filled_count,
  output logic                                             o_board_full
);
  game_state_t r_state, w_state_nxt;
  logic [BOARD_MAX-1:0][BOARD_MAX-1:0][CELL_W-1:0] r_board;
  logic [2:0] r_size;
  logic [3:0] r_row, w_cur_row, w_cur_col;
  logic [8:0] r_count, w_count_nxt, w_nn;
  logic [4:0] w_n;
  logic [CELL_W-1:0] w_old;
  logic r_full, w_accept, w_play, w_new, w_end, w_wr;
  assign bus.cmd_ready = r_state != CLEAR;
  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  assign w_play = w_accept && r_state == PLAY;
  assign w_new = w_accept && bus.cmd_code == CMD_NEW_GAME;
  assign w_end = w_play && bus.cmd_code == CMD_END_GAME;
  assign w_n = {2'b0, r_size} * {2'b0, r_size};
  assign w_nn = {4'b0, w_n} * {4'b0, w_n};
  assign w_old = r_board[w_cur_row][w_cur_col];
  assign w_wr = w_play && bus.cmd_code == CMD_WRITE && bus.cmd_digit <= w_n;
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_state_nxt = r_state == CLEAR ? (r_row == 4'd15 ? PLAY : CLEAR) :
                  w_new ? CLEAR : w_end ? IDLE : r_state;
    w_count_nxt = w_new ? '0 : !w_wr ? r_count :
                  (w_old == '0 && bus.cmd_digit != '0) ? r_count + 9'd1 :
                  (w_old != '0 && bus.cmd_digit == '0) ? r_count - 9'd1 : r_count;
  end
  // board_full looks at next-state count so it rises with the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_board <= '0;
      r_size  <= 3'(DEFAULT_SIZE);
      r_row   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= w_state_nxt == PLAY && w_count_nxt == w_nn;
      r_row   <= r_state == CLEAR ? r_row + 4'd1 : '0;
      if (w_new) r_size <= bus.size_sel inside {3'd2, 3'd3, 3'd4} ? bus.size_sel : 3'(DEFAULT_SIZE);
      if (r_state == CLEAR) r_board[r_row] <= '0;
      else if (w_wr) r_board[w_cur_row][w_cur_col] <= bus.cmd_digit;
    end
  end
  game_board_cursor u_cursor (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_new),
    .i_up   (w_play && bus.cmd_code == CMD_UP),
    .i_down (w_play && bus.cmd_code == CMD_DOWN),
    .i_left (w_play && bus.cmd_code == CMD_LEFT),
    .i_right(w_play && bus.cmd_code == CMD_RIGHT),
    .i_n    (w_n),
    .o_row  (w_cur_row),
    .o_col  (w_cur_col)
  );
  assign o_board = r_board;
  assign o_board_size = r_size;
  assign o_is_game_on = r_state == PLAY;
  assign o_cursor_row = w_cur_row;
  assign o_cursor_col = w_cur_col;
  assign o_filled_count = r_count;
  assign o_board_full = r_full;
endmodule

// File: tb/tb_game_board_ctl.sv
// tb_game_board_ctl: directed plus random command bench against a cell-array model of the game rules.
module tb_game_board_ctl;
  import game_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  game_board_ctl_if bus();
  logic [15:0][15:0][4:0] board;
  logic [2:0] bsize;
  logic on, full;
  logic [3:0] crow, ccol;
  logic [8:0] cnt;
  game_board_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_board       (board),
    .o_board_size  (bsize),
    .o_is_game_on  (on),
    .o_cursor_row  (crow),
    .o_cursor_col  (ccol),
    .o_filled_count(cnt),
    .o_board_full  (full)
  );
  int m_board[16][16];
  int m_size, m_row, m_col, m_play;
  int n_cmp = 0;
  int n_bad = 0;
  function automatic int m_n();
    return m_size * m_size;
  endfunction
  function automatic int m_count();
    int s = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (m_board[r][c] != 0) s++;
    return s;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) m_board[r][c] = 0;
    m_size = 3; m_row = 0; m_col = 0; m_play = 0;
  endtask
  task automatic check_all();
    int d = 0;
    @(negedge clk);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (board[r][c] !== 5'(m_board[r][c])) d++;
    check("ready", 32'(bus.cmd_ready), 1);
    check("size", 32'(bsize), m_size);
    check("game_on", 32'(on), m_play);
    check("row", 32'(crow), m_row);
    check("col", 32'(ccol), m_col);
    check("count", 32'(cnt), m_count());
    check("full", 32'(full), (m_play != 0 && m_count() == m_n() * m_n()) ? 1 : 0);
    check("board_cells_wrong", d, 0);
  endtask
  task automatic send(input game_cmd_t code, input int digit, input int sel);
    int w = 0;
    int n = m_n();
    bus.cmd_valid = 1'b1;
    bus.cmd_code = code;
    bus.cmd_digit = 5'(digit);
    bus.size_sel = 3'(sel);
    while (!bus.cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) check("accept_timeout", w, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.cmd_code = CMD_NOP;
    if (code == CMD_NEW_GAME) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) m_board[r][c] = 0;
      m_size = (sel >= 2 && sel <= 4) ? sel : 3;
      m_row = 0; m_col = 0; m_play = 1;
    end else if (m_play != 0) begin
      case (code)
        CMD_UP:       m_row = (m_row + n - 1) % n;
        CMD_DOWN:     m_row = (m_row + 1) % n;
        CMD_LEFT:     m_col = (m_col + n - 1) % n;
        CMD_RIGHT:    m_col = (m_col + 1) % n;
        CMD_WRITE:    if (digit <= n) m_board[m_row][m_col] = digit;
        CMD_END_GAME: m_play = 0;
        default: ;
      endcase
    end
  endtask
  task automatic wait_clear();
    int lows = 0;
    @(negedge clk);
    while (!bus.cmd_ready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    check("clear_ready_low_cycles", lows, 16);
    check("game_on_after_clear", 32'(on), 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code = CMD_NOP;
    bus.cmd_digit = '0;
    bus.size_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    send(CMD_WRITE, 3, 0);
    check_all();
    send(CMD_NEW_GAME, 0, 3);
    wait_clear();
    check_all();
    send(CMD_LEFT, 0, 0);  check_all(); check("left_wrap", 32'(ccol), 8);
    send(CMD_UP, 0, 0);    check_all(); check("up_wrap", 32'(crow), 8);
    send(CMD_RIGHT, 0, 0); check_all(); check("right_wrap", 32'(ccol), 0);
    send(CMD_DOWN, 0, 0);  check_all(); check("down_wrap", 32'(crow), 0);
    send(CMD_WRITE, 5, 0);  check_all(); check("w5_cell", 32'(board[0][0]), 5);
    send(CMD_WRITE, 7, 0);  check_all(); check("w7_count", 32'(cnt), 1);
    send(CMD_WRITE, 0, 0);  check_all(); check("erase_count", 32'(cnt), 0);
    send(CMD_WRITE, 10, 0); check_all(); check("w10_cell", 32'(board[0][0]), 0);
    repeat (60) begin
      send(game_cmd_t'($urandom_range(1, 5)), $urandom_range(0, 10), 0);
      check_all();
    end
    send(CMD_NEW_GAME, 0, 2);
    wait_clear();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(CMD_WRITE, (r + c) % 4 + 1, 0);
        check_all();
        send(CMD_RIGHT, 0, 0);
      end
      send(CMD_DOWN, 0, 0);
    end
    check("full_after_16", 32'(full), 1);
    send(CMD_WRITE, 0, 0);
    check_all();
    check("full_after_erase", 32'(full), 0);
    check("count_after_erase", 32'(cnt), 15);
    send(CMD_NEW_GAME, 0, 4);
    wait_clear();
    repeat (40) begin
      send(game_cmd_t'($urandom_range(1, 5)), $urandom_range(0, 17), 0);
      check_all();
    end
    send(CMD_NEW_GAME, 0, 5);
    wait_clear();
    check("size_clamp", 32'(bsize), 3);
    send(CMD_UP, 0, 0);
    send(CMD_WRITE, 4, 0);
    check_all();
    send(CMD_END_GAME, 0, 0);
    check_all();
    check("on_after_end", 32'(on), 0);
    send(CMD_WRITE, 7, 0);
    check_all();
    check("retained", 32'(board[8][0]), 4);
    send(CMD_NEW_GAME, 0, 4);
    repeat (8) @(negedge clk);
    check("mid_clear_ready", 32'(bus.cmd_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_board_ctl.md
# game_board_ctl

Owns the Sudoku-style board state that feeds the `game_board_numbers_draw` VGA stage, as well as the cursor and game-size registers. It accepts decoded player commands over a valid/ready handshake. It moves a wrapping cursor, writes digits into cells and runs a multi-cycle clear sequence on new game. It presents `board`, `board_size` and `is_game_on` as registered outputs to the draw pipeline.

## Interface
Parameters:
- none; board fixed at 16x16 storage, 5-bit cells

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_code  in  3  command, `game_cmd_t` (see Operation)
- cmd_digit  in  5  digit for WRITE (0 = erase)
- size_sel  in  3  requested board_size, sampled on NEW_GAME
- board  out  5x16x16  cell values [row][col], 0 = empty, 1..N digit
- board_size  out  3  current n; grid side N = n*n
- is_game_on  out  1  high in PLAY only
- cursor_row, cursor_col  out  4 each  selected cell
- filled_count  out  9  number of nonzero cells
- board_full  out  1  filled_count == N*N and is_game_on

## Operation
- Commands: NOP=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, WRITE=5, NEW_GAME=6, END_GAME=7.
- A command is accepted on a rising edge with cmd_valid && cmd_ready. The producer holds it until accepted.
- FSM states:
  - IDLE: reset state; cmd_ready=1. NEW_GAME goes to CLEAR. All other commands are accepted and ignored.
  - CLEAR: cmd_ready=0. Row counter r runs 0..15, one row zeroed per cycle. After row 15 the FSM goes to PLAY.
  - PLAY: cmd_ready=1; executes all commands. END_GAME goes to IDLE with the board retained. NEW_GAME goes to CLEAR.
- On NEW_GAME acceptance:
  - board_size latches size_sel. Values outside 2..4 latch 3.
  - The cursor resets to (0,0) and filled_count to 0.
- Cursor moves wrap within 0..N-1:
  - UP at row 0 goes to N-1; DOWN at N-1 goes to 0.
  - LEFT and RIGHT wrap the same way on col.
- WRITE at the cursor cell, with old = current cell value:
  - cmd_digit > N: ignored, no state change.
  - old=0, digit≠0: write, filled_count+1.
  - old≠0, digit=0: write, filled_count-1.
  - Otherwise: write the value, count unchanged.
- Cells outside N×N are never written except by CLEAR, so they stay 0.
- Widths:
  - N = board_size*board_size, computed to 5 bits.
  - N*N is computed to 9 bits (max 256), compared against filled_count.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1.
  - board all 0, board_size=3, is_game_on=0.
  - cursor (0,0), filled_count=0, board_full=0.
- All outputs are registered. A command accepted at edge k is visible after edge k, i.e. at cycle k+1.
- NEW_GAME accepted at edge k:
  - Edges k+1..k+16 clear rows 0..15.
  - cmd_ready=0 for cycles k+1..k+16.
  - is_game_on rises at cycle k+17, together with cmd_ready.
- board_full is registered from next-state count. It rises in the same cycle the board shows the last write.
- rst mid-CLEAR aborts to IDLE, with all reset values above applied on the next edge.
- cmd_valid while cmd_ready=0 has no effect and is not dropped; the producer holds it.

## Structure
- Shared `game_pkg`:
  - `game_cmd_t` enum.
  - `game_state_t` {IDLE, CLEAR, PLAY}.
  - Constants BOARD_MAX=16, CELL_W=5, DEFAULT_SIZE=3.
- One sub-module `game_board_cursor`: holds row/col, takes move strobes and N, and implements wrap-around. It is reset to (0,0) by rst or by a clear strobe.
- The board array and filled_count live in the top module.

## Test plan
- Reset, then NEW_GAME with size_sel=3 -> cmd_ready low for exactly 16 cycles; is_game_on=1 on cycle 17; board all 0; board_size=3.
- PLAY N=9, cursor (0,0): LEFT -> col 8; UP -> row 8; RIGHT -> col 0; DOWN -> row 0.
- WRITE digit 5 at (0,0) -> board[0][0]=5, filled_count=1; WRITE 7 -> count 1; WRITE 0 -> 0, count 0; WRITE 10 -> ignored.
- size_sel=2: write 1..4 into all 16 cells -> board_full=1 after the 16th write; erase one cell -> board_full=0, count 15.
- size_sel=5 on NEW_GAME -> board_size=3. END_GAME -> is_game_on=0 and board retained; a subsequent WRITE is ignored.
- Assert rst at the 8th CLEAR cycle -> next cycle: IDLE, cmd_ready=1, board all 0, board_size=3.
